// File: rtl/hack_mem_if.sv
// rtl/hack_mem_if.sv - request/acknowledge word read port into the Hack screen memory
interface hack_mem_if;
    logic [14:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_data;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/hack_screen_scanout.sv
// rtl/hack_screen_scanout.sv - Hack 512x256 screen words to centred VGA pixels via a two-slot prefetch
module hack_screen_scanout #(
    parameter int         H_OFFSET    = 64,
    parameter int         V_OFFSET    = 112,
    parameter int         SCREEN_BASE = 16384,
    parameter logic [2:0] FG_COLOR    = 3'b111,
    parameter logic [2:0] BG_COLOR    = 3'b000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       CounterX,
    input  logic [9:0]       CounterY,
    input  logic             inDisplayArea,
    hack_mem_if.master       mem,
    output logic [2:0]       pixel,
    output logic             underrun
);
    localparam logic [9:0]  X_LO = 10'(H_OFFSET);
    localparam logic [9:0]  X_HI = 10'(H_OFFSET + 512);
    localparam logic [9:0]  Y_LO = 10'(V_OFFSET);
    localparam logic [9:0]  Y_HI = 10'(V_OFFSET + 256);
    localparam logic [14:0] BASE = 15'(SCREEN_BASE);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q, state_d;
    logic [14:0] addr_q;
    logic [4:0]  req_tag;
    logic        req_stale;
    logic [5:0]  fetch_idx;

    logic [15:0] cur_data, nxt_data;
    logic [4:0]  cur_tag, nxt_tag;
    logic        cur_valid, nxt_valid;

    logic [8:0]  col;
    logic [7:0]  row;
    logic [4:0]  group;
    logic [3:0]  bit_idx;
    logic        row_valid, active, line_start, group_start;
    logic        hit_nxt, hit_cur, promote, miss;
    logic        ack_evt, stale_now, nxt_free_after, accept, start_req;
    logic [2:0]  pix_d;

    // Only the low bits of the offsets matter for the in-window coordinates.
    assign col     = CounterX[8:0] - X_LO[8:0];
    assign row     = CounterY[7:0] - Y_LO[7:0];
    assign group   = col[8:4];
    assign bit_idx = col[3:0];

    assign row_valid   = (CounterY >= Y_LO) && (CounterY < Y_HI);
    assign active      = inDisplayArea && row_valid && (CounterX >= X_LO) && (CounterX < X_HI);
    assign line_start  = row_valid && (CounterX == 10'd0);
    assign group_start = active && (bit_idx == 4'd0);

    assign hit_nxt = nxt_valid && (nxt_tag == group);
    assign hit_cur = cur_valid && (cur_tag == group);
    assign promote = group_start && hit_nxt;
    assign miss    = group_start && !hit_nxt && !hit_cur;

    // Slot bookkeeping of this cycle is resolved before the ack, so a slot freed
    // by promotion or discard can take the arriving word.
    assign ack_evt        = (state_q == REQ) && mem.mem_ack;
    assign stale_now      = req_stale || line_start || (miss && (req_tag <= group));
    assign nxt_free_after = !nxt_valid || promote || (miss && (nxt_tag <= group));
    assign accept         = ack_evt && !stale_now && nxt_free_after;

    assign start_req = (state_q == IDLE) && row_valid && !line_start && !group_start
                       && !fetch_idx[5] && !nxt_valid;

    assign mem.mem_req  = (state_q == REQ);
    assign mem.mem_addr = addr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_req) state_d = REQ;
            REQ:  if (mem.mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pix_d = BG_COLOR;
        if (active) begin
            if (promote)
                pix_d = nxt_data[0] ? FG_COLOR : BG_COLOR;
            else if (hit_cur)
                pix_d = cur_data[bit_idx] ? FG_COLOR : BG_COLOR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel     <= 3'b000;
            underrun  <= 1'b0;
            addr_q    <= '0;
            req_tag   <= '0;
            req_stale <= 1'b0;
            fetch_idx <= '0;
            cur_data  <= '0;
            cur_tag   <= '0;
            cur_valid <= 1'b0;
            nxt_data  <= '0;
            nxt_tag   <= '0;
            nxt_valid <= 1'b0;
        end else begin
            pixel <= pix_d;
            if (miss)
                underrun <= 1'b1;

            if (start_req) begin
                addr_q    <= BASE + {2'b00, row, fetch_idx[4:0]};
                req_tag   <= fetch_idx[4:0];
                req_stale <= 1'b0;
            end else if ((state_q == REQ) && (line_start || (miss && (req_tag <= group)))) begin
                req_stale <= 1'b1;
            end

            if (line_start) begin
                cur_valid <= 1'b0;
                nxt_valid <= 1'b0;
                fetch_idx <= '0;
            end else begin
                if (promote) begin
                    cur_data  <= nxt_data;
                    cur_tag   <= nxt_tag;
                    cur_valid <= 1'b1;
                    nxt_valid <= 1'b0;
                end
                // A missed group stays blank; skip the fetch pointer past it.
                if (miss) begin
                    if (cur_tag <= group)
                        cur_valid <= 1'b0;
                    if (nxt_tag <= group)
                        nxt_valid <= 1'b0;
                    if (fetch_idx <= {1'b0, group})
                        fetch_idx <= {1'b0, group} + 6'd1;
                end
                if (accept) begin
                    nxt_data  <= mem.mem_data;
                    nxt_tag   <= req_tag;
                    nxt_valid <= 1'b1;
                    fetch_idx <= {1'b0, req_tag} + 6'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_hack_screen_scanout.sv
// tb/tb_hack_screen_scanout.sv - randomized bench for hack_screen_scanout against a pixel-map model
module tb_hack_screen_scanout;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] cx, cy;
    logic       disp;
    logic [2:0] pixel;
    logic       underrun;

    hack_mem_if mif();

    hack_screen_scanout dut (
        .clk           (clk),
        .reset         (reset),
        .CounterX      (cx),
        .CounterY      (cy),
        .inDisplayArea (disp),
        .mem           (mif),
        .pixel         (pixel),
        .underrun      (underrun)
    );

    always #20 clk = ~clk;

    logic [15:0] mem_arr [0:8191];
    logic [2:0]  line_pix [0:799];
    logic [14:0] req_log [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          req_cycles = 0;
    int          lat_mode = 0;
    bit          auto_mem = 1'b1;
    logic        resp_ack, man_ack;
    logic [15:0] resp_data, man_data;

    assign mif.mem_ack  = auto_mem ? resp_ack  : man_ack;
    assign mif.mem_data = auto_mem ? resp_data : man_data;

    // Memory: acks after lat_mode cycles (or a random 0..10 when lat_mode < 0).
    initial begin
        int  wait_cnt;
        int  cur_lat;
        int  idx;
        bit  in_req;
        resp_ack  = 1'b0;
        resp_data = '0;
        wait_cnt  = 0;
        cur_lat   = 0;
        in_req    = 1'b0;
        forever begin
            @(negedge clk);
            if (mif.mem_req) req_cycles++;
            if (auto_mem && mif.mem_req) begin
                if (!in_req) begin
                    in_req   = 1'b1;
                    wait_cnt = 0;
                    cur_lat  = (lat_mode < 0) ? int'($urandom_range(0, 10)) : lat_mode;
                end
                if (wait_cnt == cur_lat) begin
                    idx = int'(mif.mem_addr) - 16384;
                    resp_data = (idx >= 0 && idx < 8192) ? mem_arr[idx] : 16'h0000;
                    resp_ack  = 1'b1;
                    req_log.push_back(mif.mem_addr);
                    in_req    = 1'b0;
                end else begin
                    resp_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                resp_ack = 1'b0;
                in_req   = 1'b0;
            end
        end
    end

    function automatic logic [2:0] exp_pix(input int x, input int y);
        logic [15:0] w;
        if (x < 640 && y < 480 && x >= 64 && x < 576 && y >= 112 && y < 368) begin
            w = mem_arr[(y - 112) * 32 + (x - 64) / 16];
            return w[(x - 64) % 16] ? 3'b111 : 3'b000;
        end
        return 3'b000;
    endfunction

    task automatic drive(input int x, input int y);
        cx   = 10'(x);
        cy   = 10'(y);
        disp = (x < 640) && (y < 480);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8192; i++) mem_arr[i] = 16'($urandom);
    endtask

    task automatic run_line(input int y, input bit chk);
        for (int x = 0; x < 800; x++) begin
            drive(x, y);
            @(posedge clk);
            #1;
            line_pix[x] = pixel;
            if (chk) begin
                vectors++;
                if (pixel !== exp_pix(x, y)) begin
                    miscompares++;
                    $display("FAIL pixel x=%0d y=%0d: got %0d want %0d", x, y, pixel, exp_pix(x, y));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0);
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (pixel !== 3'b000) begin miscompares++; $display("FAIL reset_pixel: got %0d want 0", pixel); end
        vectors++; if (mif.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %0b want 0", mif.mem_req); end
        vectors++; if (mif.mem_addr !== 15'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", mif.mem_addr); end
        vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun: got %0b want 0", underrun); end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_border();
        int lines [7] = '{0, 50, 111, 368, 400, 479, 524};
        fill_random();
        lat_mode = -1;
        foreach (lines[i]) begin
            req_cycles = 0;
            run_line(lines[i], 1'b1);
            vectors++;
            if (req_cycles !== 0) begin
                miscompares++;
                $display("FAIL border_req y=%0d: got %0d request cycles want 0", lines[i], req_cycles);
            end
        end
        vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL border_underrun: got %0b want 0", underrun); end
    endtask

    task automatic test_first_word();
        for (int i = 0; i < 8192; i++) mem_arr[i] = 16'h0000;
        mem_arr[0] = 16'h0001;
        lat_mode = 0;
        run_line(112, 1'b1);
        vectors++; if (line_pix[64] !== 3'b111) begin miscompares++; $display("FAIL first_word_x64: got %0d want 7", line_pix[64]); end
        vectors++; if (line_pix[63] !== 3'b000) begin miscompares++; $display("FAIL first_word_x63: got %0d want 0", line_pix[63]); end
    endtask

    task automatic test_addressing();
        fill_random();
        lat_mode = -1;
        req_log.delete();
        run_line(117, 1'b1);
        vectors++;
        if (req_log.size() != 32) begin
            miscompares++;
            $display("FAIL addr_count: got %0d requests want 32", req_log.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                vectors++;
                if (req_log[i] !== 15'(16384 + 160 + i)) begin
                    miscompares++;
                    $display("FAIL addr_seq[%0d]: got %0d want %0d", i, req_log[i], 16384 + 160 + i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        lat_mode = -1;
        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_line(int'($urandom_range(112, 367)), 1'b1);
        end
        run_line(367, 1'b1);
        run_line(368, 1'b1);
        vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL random_underrun: got %0b want 0", underrun); end
    endtask

    task automatic test_underrun();
        int bg_groups;
        for (int i = 0; i < 8192; i++) mem_arr[i] = 16'hFFFF;
        lat_mode = 20;
        run_line(200, 1'b0);
        bg_groups = 0;
        vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL underrun_flag: got %0b want 1", underrun); end
        for (int g = 0; g < 32; g++) begin
            logic [2:0] c;
            bit mixed;
            c = line_pix[64 + 16 * g];
            mixed = (c !== 3'b000) && (c !== 3'b111);
            for (int b = 1; b < 16; b++) if (line_pix[64 + 16 * g + b] !== c) mixed = 1'b1;
            if (c === 3'b000) bg_groups++;
            vectors++;
            if (mixed) begin
                miscompares++;
                $display("FAIL underrun_group %0d: got mixed colours want one of 0 or 7", g);
            end
        end
        vectors++; if (line_pix[64] !== 3'b111) begin miscompares++; $display("FAIL underrun_group0: got %0d want 7", line_pix[64]); end
        vectors++; if (bg_groups < 1) begin miscompares++; $display("FAIL underrun_blank: got %0d blank groups want >=1", bg_groups); end
        vectors++; if (line_pix[10] !== 3'b000 || line_pix[600] !== 3'b000) begin
            miscompares++; $display("FAIL underrun_border: got %0d/%0d want 0/0", line_pix[10], line_pix[600]);
        end
    endtask

    task automatic test_reset_mid_req();
        bit seen;
        auto_mem = 1'b0;
        man_ack  = 1'b0;
        man_data = 16'hFFFF;
        seen = 1'b0;
        for (int x = 0; x < 12 && !seen; x++) begin
            drive(x, 112);
            @(posedge clk);
            #1;
            seen = (mif.mem_req === 1'b1);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL mid_req_timeout: got no mem_req want mem_req within 12 cycles");
        end
        reset = 1'b1;
        #1;
        vectors++; if (mif.mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_req_drop: got %0b want 0", mif.mem_req); end
        drive(0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        man_ack = 1'b1;
        vectors++; if (mif.mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_req_idle: got %0b want 0", mif.mem_req); end
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        for (int x = 60; x <= 64; x++) begin
            drive(x, 112);
            @(posedge clk);
            #1;
        end
        vectors++; if (pixel !== 3'b000) begin miscompares++; $display("FAIL mid_req_slot: got %0d want 0", pixel); end
        vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL mid_req_underrun: got %0b want 1", underrun); end
        auto_mem = 1'b1;
    endtask

    initial begin
        man_ack  = 1'b0;
        man_data = '0;
        test_reset();
        test_border();
        test_first_word();
        test_addressing();
        test_back_to_back();
        test_underrun();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
